// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   state_e     : load/commit handshake states
//   Seg*        : active-low segment patterns, bit 6 = a ... bit 0 = g
package seven_seg_scan_ctrl_pkg;

  typedef enum logic {StIdle, StPending} state_e;

  localparam logic [6:0] SegZero  = 7'b0000001;
  localparam logic [6:0] SegOne   = 7'b1001111;
  localparam logic [6:0] SegTwo   = 7'b0010010;
  localparam logic [6:0] SegThree = 7'b0000110;
  localparam logic [6:0] SegFour  = 7'b1001100;
  localparam logic [6:0] SegFive  = 7'b0100100;
  localparam logic [6:0] SegSix   = 7'b0100000;
  localparam logic [6:0] SegSeven = 7'b0001111;
  localparam logic [6:0] SegEight = 7'b0000000;
  localparam logic [6:0] SegNine  = 7'b0000100;
  localparam logic [6:0] SegDash  = 7'b1111110;
  localparam logic [6:0] SegBlank = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern.
//   nibble : 4-bit value to show
//   seg    : abcdefg pattern (bit 6 = a); values 10-15 show a dash
module seg7_decode
  import seven_seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SegDash;
    case (nibble)
      4'd0:    seg = SegZero;
      4'd1:    seg = SegOne;
      4'd2:    seg = SegTwo;
      4'd3:    seg = SegThree;
      4'd4:    seg = SegFour;
      4'd5:    seg = SegFive;
      4'd6:    seg = SegSix;
      4'd7:    seg = SegSeven;
      4'd8:    seg = SegEight;
      4'd9:    seg = SegNine;
      default: seg = SegDash;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
//   clk, rst  : clock and synchronous active-high reset
//   load      : capture bcd_in when ready=1
//   bcd_in    : four BCD nibbles, [3:0] = digit 0
//   blank_lz  : blank leading zeros (digit 0 always shown)
//   ready     : handshake idle, a load will be accepted
//   an        : active-low digit enables (registered)
//   disp      : active-low abcdefg segments (registered)
// New values land in a shadow register and only move to the displayed
// register on a frame boundary, so a frame never shows a mix of old and new.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 4,
  parameter int unsigned DIGITS      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [15:0]       bcd_in,
  input  logic              blank_lz,
  output logic              ready,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        disp
);

  localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0]   count_q, count_d;
  logic [1:0]        idx_q, idx_d;
  logic              tick, frame_end;
  state_e            state_q, state_d;
  logic [15:0]       shadow_q, shadow_d;
  logic [15:0]       active_q, active_d;
  logic [3:0]        nibble;
  logic [6:0]        seg_raw;
  logic              lead_zero;
  logic [DIGITS-1:0] an_d;
  logic [6:0]        disp_d;

  // Prescaler, digit index and handshake FSM next-state.
  always_comb begin
    tick      = (count_q == CntMax);
    count_d   = tick ? '0 : count_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    frame_end = tick && (idx_q == 2'd3);

    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          shadow_d = bcd_in;
          state_d  = StPending;
        end
      end
      StPending: begin
        if (frame_end) begin
          active_d = shadow_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    ready = (state_q == StIdle);
  end

  // One decoder shared by all digits; the index selects which nibble it sees.
  assign nibble = active_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (seg_raw)
  );

  // A digit is a leading zero when it and every more-significant nibble is 0.
  always_comb begin
    lead_zero = blank_lz && (idx_q != 2'd0) && ((active_q >> {idx_q, 2'b00}) == 16'h0);
    disp_d    = lead_zero ? SegBlank : seg_raw;
    an_d      = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      idx_q    <= '0;
      state_q  <= StIdle;
      shadow_q <= '0;
      active_q <= '0;
      an       <= '1;
      disp     <= SegBlank;
    end else begin
      count_q  <= count_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      an       <= an_d;
      disp     <= disp_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with REFRESH_DIV=4 (16-clock frames).
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic        blank_lz;
  logic        ready;
  logic [3:0]  an;
  logic [6:0]  disp;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;   // clock edges since reset release

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] SD = 7'b1111110;
  localparam logic [6:0] SB = 7'b1111111;

  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .REFRESH_DIV (4),
    .DIGITS      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .bcd_in   (bcd_in),
    .blank_lz (blank_lz),
    .ready    (ready),
    .an       (an),
    .disp     (disp)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance n edges, checking the scanned digit enable and its pattern.
  // After edge k the outputs show slot ((k-1)/4)%4.
  task automatic run(input int n, input logic [6:0] d0, input logic [6:0] d1,
                     input logic [6:0] d2, input logic [6:0] d3);
    logic [6:0] exp_d [4];
    int slot;
    exp_d = '{d0, d1, d2, d3};
    for (int i = 0; i < n; i++) begin
      step();
      slot = ((cyc - 1) / 4) % 4;
      chk($sformatf("an@%0d", cyc), {12'h0, an}, {12'h0, an_tab[slot]});
      chk($sformatf("disp@%0d", cyc), {9'h0, disp}, {9'h0, exp_d[slot]});
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; bcd_in = 16'h0; blank_lz = 1'b0;
    step();
    step();
    chk("rst_an", {12'h0, an}, 16'h000f);
    chk("rst_disp", {9'h0, disp}, {9'h0, SB});
    chk("rst_ready", {15'h0, ready}, 16'h0001);
    rst = 1'b0;
    cyc = 0;

    // Empty display, then leading-zero blanking of digits 1-3.
    run(16, S0, S0, S0, S0);
    blank_lz = 1'b1;
    run(16, S0, SB, SB, SB);

    // Load 1234; a second load while pending must be ignored.
    blank_lz = 1'b0;
    load = 1'b1; bcd_in = 16'h1234;
    step();
    chk("ready_after_load", {15'h0, ready}, 16'h0000);
    bcd_in = 16'h9999;
    run(1, S0, S0, S0, S0);
    chk("ready_pending", {15'h0, ready}, 16'h0000);
    load = 1'b0; bcd_in = 16'h0;
    run(13, S0, S0, S0, S0);
    chk("ready_before_commit", {15'h0, ready}, 16'h0000);
    run(1, S0, S0, S0, S0);
    chk("ready_after_commit", {15'h0, ready}, 16'h0001);
    run(16, S4, S3, S2, S1);

    // Load 00A5 exactly on the frame-boundary edge (cycle 80).
    run(15, S4, S3, S2, S1);
    load = 1'b1; bcd_in = 16'h00a5;
    run(1, S4, S3, S2, S1);
    load = 1'b0; bcd_in = 16'h0;
    run(1, S4, S3, S2, S1);
    chk("boundary_load_pending", {15'h0, ready}, 16'h0000);
    run(14, S4, S3, S2, S1);
    chk("boundary_load_still_pending", {15'h0, ready}, 16'h0000);
    run(1, S4, S3, S2, S1);
    chk("boundary_load_commit", {15'h0, ready}, 16'h0001);
    run(16, S5, SD, S0, S0);
    blank_lz = 1'b1;
    run(16, S5, SD, SB, SB);

    // Reset while pending discards the shadow value.
    blank_lz = 1'b0;
    load = 1'b1; bcd_in = 16'h8888;
    step();
    chk("pending_8888", {15'h0, ready}, 16'h0000);
    load = 1'b0; bcd_in = 16'h0;
    step();
    rst = 1'b1;
    step();
    chk("rst2_an", {12'h0, an}, 16'h000f);
    chk("rst2_disp", {9'h0, disp}, {9'h0, SB});
    chk("rst2_ready", {15'h0, ready}, 16'h0001);
    rst = 1'b0;
    cyc = 0;
    run(32, S0, S0, S0, S0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
